// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SLC-3 memory access controller.
// Holds the FSM state encoding, the MMIO address and the wait-counter width helper.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

   // Smallest width that can hold max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) w++;
      return w;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter with terminal-count (zero) flag.
// Holds at zero; load has priority over decrement.
module mem_wait_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// SLC-3 SRAM responder: accepts one CPU access, drives strobes for WAIT_CYCLES, returns read data.
// Optional MEM_MMIO_EN: address xFFFF maps to board switches (read) and hex display register (write).
//
// state  | meaning
// IDLE   | ready for a request; strobes inactive
// ACCESS | SRAM strobes asserted while the wait timer runs down
// DONE   | strobes released; one-cycle rsp_valid
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] hex_out
);

   localparam int               CNT_W     = cnt_width(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t state, state_nxt;
   logic   accept;
   logic   mmio_hit;
   logic   we_q;
   logic   wait_zero;
   logic   last_access;

   assign accept      = req_valid && (state == IDLE);
   assign last_access = (state == ACCESS) && wait_zero;

`ifdef MEM_MMIO_EN
   assign mmio_hit = (req_addr == ADDR_W'(MMIO_ADDR));
`else
   assign mmio_hit = 1'b0;
`endif

   mem_wait_timer #(
      .WIDTH (CNT_W)
   ) u_wait_timer (
      .clk_sys  (Clk),
      .rst_b    (Reset_n),
      .load     (accept),
      .load_val (WAIT_LOAD),
      .dec      (state == ACCESS),
      .zero     (wait_zero)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Strobes decode straight from state so an async reset releases them at once.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_ce_n  = 1'b1;
      mem_oe_n  = 1'b1;
      mem_we_n  = 1'b1;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = mmio_hit ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            mem_ce_n = 1'b0;
            mem_oe_n = we_q;
            mem_we_n = !we_q;
            if (wait_zero) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         we_q      <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            we_q      <= req_we;
         end
         if (last_access && !we_q) begin
            rsp_rdata <= mem_rdata;
         end
`ifdef MEM_MMIO_EN
         if (accept && mmio_hit && !req_we) begin
            rsp_rdata <= sw;
         end
`endif
      end
   end

`ifdef MEM_MMIO_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hex_out <= '0;
      end else if (accept && mmio_hit && req_we) begin
         hex_out <= req_wdata;
      end
   end
`else
   logic unused_sw;
   assign unused_sw = ^sw;
   assign hex_out   = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: main instance at WAIT_CYCLES=2, second at WAIT_CYCLES=1.
module tb_mem_access_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid;
   logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata, hex_out;
   logic        mem_ce_n, mem_oe_n, mem_we_n;
   logic [15:0] sw = '0;

   logic        r1_valid = 1'b0, r1_we = 1'b0;
   logic [15:0] r1_addr = '0, r1_wdata = '0;
   logic        r1_ready, r1_rsp_valid;
   logic [15:0] r1_rdata, m1_addr, m1_wdata, m1_rdata, hex1_out;
   logic        m1_ce_n, m1_oe_n, m1_we_n;

   logic [15:0] ram  [0:65535];
   logic [15:0] ram1 [0:65535];

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) dut (
      .Clk(clk), .Reset_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ce_n(mem_ce_n),
      .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .sw(sw), .hex_out(hex_out)
   );

   mem_access_ctrl #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dut1 (
      .Clk(clk), .Reset_n(rst_n), .req_valid(r1_valid), .req_we(r1_we),
      .req_addr(r1_addr), .req_wdata(r1_wdata), .req_ready(r1_ready),
      .rsp_valid(r1_rsp_valid), .rsp_rdata(r1_rdata), .mem_addr(m1_addr),
      .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .mem_ce_n(m1_ce_n),
      .mem_oe_n(m1_oe_n), .mem_we_n(m1_we_n), .sw(sw), .hex_out(hex1_out)
   );

   assign mem_rdata = ram[mem_addr];
   assign m1_rdata  = ram1[m1_addr];

   always @(posedge clk) begin
      if (!mem_ce_n && !mem_we_n) ram[mem_addr] = mem_wdata;
      if (!m1_ce_n && !m1_we_n) ram1[m1_addr] = m1_wdata;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Transaction-level model
   logic [15:0] model [logic [15:0]];
   logic [15:0] exp_q [$];
   int          cyc_q [$];
   int          acc_cyc [$];
   logic [15:0] last_rd = '0;
   int          cyc = 0;

   function automatic logic [15:0] mread(input logic [15:0] a);
      return model.exists(a) ? model[a] : (a ^ 16'h5A5A);
   endfunction

   always @(posedge clk) begin : acc_mon
      logic [15:0] e;
      int          lat;
      if (rst_n && req_valid && req_ready) begin
         acc_cyc.push_back(cyc);
         lat = W + 1;
`ifdef MEM_MMIO_EN
         if (req_addr == 16'hFFFF) begin
            lat = 1;
            if (req_we) e = last_rd;
            else begin
               e = sw;
               last_rd = sw;
            end
         end else
`endif
         if (req_we) begin
            model[req_addr] = req_wdata;
            e = last_rd;
         end else begin
            e = mread(req_addr);
            last_rd = e;
         end
         exp_q.push_back(e);
         cyc_q.push_back(cyc + lat);
      end
      cyc++;
   end

   logic prev_rsp = 1'b0;
   int   we_run = 0, last_we_run = 0, ce_low_cnt = 0;

   always @(negedge clk) begin : rsp_mon
      logic [15:0] e;
      int          c;
      if (rsp_valid) begin
         chk("rsp_b2b", {31'd0, prev_rsp}, 0);
         if (exp_q.size() == 0) begin
            chk("rsp_spurious", 1, 0);
         end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e});
            chk("rsp_cycle", cyc, c);
         end
      end
      prev_rsp = rsp_valid;
      if (!mem_we_n) we_run++;
      else if (we_run != 0) begin
         last_we_run = we_run;
         we_run = 0;
      end
      if (!mem_ce_n) ce_low_cnt++;
      if (!mem_we_n && !mem_oe_n) chk("oe_we_overlap", 1, 0);
   end

   task automatic flush_model;
      exp_q.delete();
      cyc_q.delete();
      last_rd = '0;
      we_run = 0;
   endtask

   task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'd0, n < 40}, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain;
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain", {31'd0, n < 40}, 1);
      @(negedge clk);
   endtask

   initial begin : wdog
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : main
      int base, n, we_cnt, oe_cnt, rsp_at, rsp_cnt;
      logic [15:0] a, d;
      for (int i = 0; i < 65536; i++) begin
         ram[i]  = 16'(i) ^ 16'h5A5A;
         ram1[i] = 16'(i) ^ 16'h5A5A;
      end

      repeat (3) @(negedge clk);
      chk("rst_ce_n", {31'd0, mem_ce_n}, 1);
      chk("rst_oe_n", {31'd0, mem_oe_n}, 1);
      chk("rst_we_n", {31'd0, mem_we_n}, 1);
      chk("rst_ready", {31'd0, req_ready}, 1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("rst_rdata", {16'd0, rsp_rdata}, 0);
      chk("rst_hex", {16'd0, hex_out}, 0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1'b1, 16'h3000, 16'h1234);
      drain();
      chk("we_pulse_len", last_we_run, W);
      issue(1'b0, 16'h3000, 16'h0000);
      drain();
      chk("rdata_hold", {16'd0, rsp_rdata}, 16'h1234);

      for (int k = 0; k < 5; k++) begin
         a = 16'h4000 + 16'($urandom_range(0, 255));
         d = 16'($urandom);
         issue(1'b1, a, d);
         issue(1'b0, a, 16'h0000);
         issue(1'b0, a + 16'h0100, 16'h0000);
      end
      issue(1'b0, 16'h0000, 16'h0000);
      drain();

      // req_valid held high across consecutive reads
      base = acc_cyc.size();
      @(negedge clk);
      req_we = 1'b0;
      req_addr = 16'h3000;
      req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (acc_cyc.size() < base + k + 1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("b2b_accept", {31'd0, n < 20}, 1);
         req_addr = 16'h3001 + 16'(k);
      end
      req_valid = 1'b0;
      drain();
      for (int k = 0; k < 3; k++) begin
         if (acc_cyc.size() > base + k + 1)
            chk("b2b_spacing", acc_cyc[base+k+1] - acc_cyc[base+k], W + 2);
         else
            chk("b2b_count", acc_cyc.size(), base + 4);
      end

      // Reset during the second ACCESS cycle of a write
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h5000;
      req_wdata = 16'hCAFE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("mid_ce_low", {31'd0, mem_ce_n}, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      flush_model();
      #1;
      chk("arst_ce_n", {31'd0, mem_ce_n}, 1);
      chk("arst_we_n", {31'd0, mem_we_n}, 1);
      chk("arst_oe_n", {31'd0, mem_oe_n}, 1);
      chk("arst_ready", {31'd0, req_ready}, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 1);
      chk("post_rst_rdata", {16'd0, rsp_rdata}, 0);
      issue(1'b0, 16'h3000, 16'h0000);
      drain();

`ifdef MEM_MMIO_EN
      sw = 16'hBEEF;
      ce_low_cnt = 0;
      issue(1'b0, 16'hFFFF, 16'h0000);
      drain();
      chk("mmio_rd_ce", ce_low_cnt, 0);
      issue(1'b1, 16'hFFFF, 16'h00AB);
      drain();
      chk("mmio_wr_ce", ce_low_cnt, 0);
      chk("mmio_hex", {16'd0, hex_out}, 16'h00AB);
      chk("mmio_rdata_hold", {16'd0, rsp_rdata}, 16'hBEEF);
`else
      sw = 16'hBEEF;
      ce_low_cnt = 0;
      issue(1'b1, 16'hFFFF, 16'h7777);
      drain();
      chk("top_we_pulse", last_we_run, W);
      chk("top_ce_cycles", ce_low_cnt, W);
      chk("top_hex", {16'd0, hex_out}, 0);
      issue(1'b0, 16'hFFFF, 16'h0000);
      drain();
      chk("top_rdata", {16'd0, rsp_rdata}, 16'h7777);
`endif

      // WAIT_CYCLES=1 instance: write then read
      @(negedge clk);
      chk("w1_ready", {31'd0, r1_ready}, 1);
      r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 16'h3000; r1_wdata = 16'h1234;
      @(posedge clk);
      #1 r1_valid = 1'b0;
      we_cnt = 0; rsp_at = 0; rsp_cnt = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (!m1_we_n) we_cnt++;
         if (r1_rsp_valid) begin
            rsp_cnt++;
            rsp_at = i;
         end
      end
      chk("w1_we_cycles", we_cnt, 1);
      chk("w1_wr_rsp_at", rsp_at, 2);
      chk("w1_wr_rsp_cnt", rsp_cnt, 1);
      r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 16'h3000;
      @(posedge clk);
      #1 r1_valid = 1'b0;
      oe_cnt = 0; rsp_at = 0; rsp_cnt = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (!m1_oe_n) oe_cnt++;
         if (r1_rsp_valid) begin
            rsp_cnt++;
            rsp_at = i;
            chk("w1_rdata", {16'd0, r1_rdata}, 16'h1234);
         end
      end
      chk("w1_oe_cycles", oe_cnt, 1);
      chk("w1_rd_rsp_at", rsp_at, 2);
      chk("w1_rd_rsp_cnt", rsp_cnt, 1);
      chk("w1_hex", {16'd0, hex1_out}, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
